// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1-to-N demultiplexer:
//   - mode encodings for the target selection (direct S vs. auto-scan)
//   - default channel count / data width
//   - clog2 helper usable in parameter defaults
// ---------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } demux_mode_e;

    localparam logic DEMUX_MODE_DIRECT = MODE_DIRECT;
    localparam logic DEMUX_MODE_SCAN   = MODE_SCAN;

    localparam int DEMUX_N_OUT_DEFAULT  = 8;
    localparam int DEMUX_DATA_W_DEFAULT = 1;

    // Ceiling log2, minimum result 1 so a select bus never collapses to
    // zero width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
// One-entry output register for a single demux channel.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears data and valid)
//   ld             load d into the slot this cycle
//   drain          consumer ready for this channel; empties a full slot
//                  unless a load happens in the same cycle
//   d              data to load
//   q              held data (kept after drain, not zeroed)
//   valid          slot holds an unconsumed beat
//   ready_for_load slot can take a beat this cycle (empty, or draining)
// ---------------------------------------------------------------------------
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              drain,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid,
    output logic              ready_for_load
);

    logic [DATA_W-1:0] q_reg;
    logic              valid_reg;
    logic              valid_next;

    // Load has priority over drain so a full slot can pass one beat per
    // cycle when the consumer is ready.
    always_comb begin
        valid_next = valid_reg;
        if (ld) begin
            valid_next = 1'b1;
        end else if (valid_reg && drain) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            if (ld) begin
                q_reg <= d;
            end
        end
    end

    assign q              = q_reg;
    assign valid          = valid_reg;
    assign ready_for_load = ~valid_reg | drain;

endmodule

// File: rtl/demux_1ton_reg.sv
// ---------------------------------------------------------------------------
// demux_1ton_reg
// Registered 1-to-N demultiplexer with valid/ready flow control. Each input
// beat goes to one channel, chosen either by S (mode=0) or by an internal
// round-robin scan counter (mode=1). Every channel owns a one-entry output
// register; data appears on O/o_valid one cycle after acceptance.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   I         input data (DATA_W)
//   S         channel select, used when mode=0 (SEL_W)
//   in_valid  input beat present
//   in_ready  beat can be accepted this cycle (combinational)
//   mode      0 = direct select via S, 1 = auto-scan
//   O         channel k data at O[k*DATA_W +: DATA_W]
//   o_valid   per-channel valid
//   o_ready   per-channel consumer ready
//   cur_sel   channel targeted this cycle (combinational)
//   sel_err   sticky: a beat was accepted with an out-of-range target
// ---------------------------------------------------------------------------
module demux_1ton_reg
    import demux_pkg::*;
#(
    parameter int N_OUT  = DEMUX_N_OUT_DEFAULT,
    parameter int DATA_W = DEMUX_DATA_W_DEFAULT,
    parameter int SEL_W  = clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       I,
    input  logic [SEL_W-1:0]        S,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    output logic [N_OUT*DATA_W-1:0] O,
    output logic [N_OUT-1:0]        o_valid,
    input  logic [N_OUT-1:0]        o_ready,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    sel_err
);

    // One extra bit so N_OUT itself is representable for the range check.
    localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0] scan_cnt_reg;
    logic [SEL_W-1:0] scan_cnt_next;
    logic             sel_err_reg;
    logic             sel_err_next;
    logic [SEL_W-1:0] tgt;
    logic             tgt_ok;
    logic             acc;
    logic [N_OUT-1:0] tgt_hit;
    logic [N_OUT-1:0] slot_ld;
    logic [N_OUT-1:0] slot_rdy;

    // Target is combinational so a mode change steers the very beat that
    // is presented in the same cycle; beats already held are never moved.
    assign tgt     = (mode == DEMUX_MODE_SCAN) ? scan_cnt_reg : S;
    assign cur_sel = tgt;

    // Only S can fall outside [0, N_OUT-1] (non power-of-two N_OUT); the
    // scan counter wraps explicitly at LAST_SEL.
    assign tgt_ok = ({1'b0, tgt} < N_OUT_EXT);

    // Out-of-range beats are swallowed (ready=1) so the producer never
    // stalls on a bad select; sel_err records that it happened.
    assign in_ready = ~tgt_ok | (|(tgt_hit & slot_rdy));
    assign acc      = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi = gi + 1) begin : g_slot
            assign tgt_hit[gi] = (tgt == SEL_W'(gi));
            assign slot_ld[gi] = acc & tgt_ok & tgt_hit[gi];

            demux_out_slot #(
                .DATA_W(DATA_W)
            ) u_slot (
                .clk           (clk),
                .rst           (rst),
                .ld            (slot_ld[gi]),
                .drain         (o_ready[gi]),
                .d             (I),
                .q             (O[gi*DATA_W +: DATA_W]),
                .valid         (o_valid[gi]),
                .ready_for_load(slot_rdy[gi])
            );
        end
    endgenerate

    // Scan counter advances only on accepted beats in scan mode; it keeps
    // its position across mode changes.
    always_comb begin
        scan_cnt_next = scan_cnt_reg;
        if (acc && (mode == DEMUX_MODE_SCAN)) begin
            if (scan_cnt_reg == LAST_SEL) begin
                scan_cnt_next = '0;
            end else begin
                scan_cnt_next = scan_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        sel_err_next = sel_err_reg;
        if (acc && !tgt_ok) begin
            sel_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            sel_err_reg  <= 1'b0;
        end else begin
            scan_cnt_reg <= scan_cnt_next;
            sel_err_reg  <= sel_err_next;
        end
    end

    assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_demux_1ton_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1ton_reg
// Directed bench for demux_1ton_reg: an 8-channel instance driven by a
// vector table (direct sweep + auto-scan) and hand sequences, plus a
// 6-channel instance for out-of-range selects.
// ---------------------------------------------------------------------------
module tb_demux_1ton_reg;

    logic       clk;
    logic       rst;

    // 8-channel DUT
    logic       i8;
    logic [2:0] s8;
    logic       v8;
    logic       rdy8;
    logic       m8;
    logic [7:0] o8;
    logic [7:0] ov8;
    logic [7:0] ordy8;
    logic [2:0] cur8;
    logic       err8;

    // 6-channel DUT
    logic       i6;
    logic [2:0] s6;
    logic       v6;
    logic       rdy6;
    logic       m6;
    logic [5:0] o6;
    logic [5:0] ov6;
    logic [5:0] ordy6;
    logic [2:0] cur6;
    logic       err6;

    int pass_cnt;
    int total_cnt;

    demux_1ton_reg #(.N_OUT(8), .DATA_W(1), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .I(i8), .S(s8), .in_valid(v8), .in_ready(rdy8),
        .mode(m8), .O(o8), .o_valid(ov8), .o_ready(ordy8), .cur_sel(cur8),
        .sel_err(err8)
    );

    demux_1ton_reg #(.N_OUT(6), .DATA_W(1), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .I(i6), .S(s6), .in_valid(v6), .in_ready(rdy6),
        .mode(m6), .O(o6), .o_valid(ov6), .o_ready(ordy6), .cur_sel(cur6),
        .sel_err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [2:0] s;
        logic       i;
        logic       v;
        logic [7:0] ordy;
        logic       exp_rdy;
        logic [2:0] exp_cur;
        logic [7:0] exp_ov;
        logic [7:0] exp_o;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic m, input logic [2:0] s, input logic i,
                          input logic v, input logic [7:0] ordy);
        m8 = m; s8 = s; i8 = i; v8 = v; ordy8 = ordy;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        // Vector table: direct sweep S=0..7 then 10 auto-scan beats.
        // With all o_ready=1 each slot drains the cycle after it loads, so
        // o_valid is one-hot while O keeps every written bit.
        for (int k = 0; k < 8; k++) begin
            vecs[k].m       = 1'b0;
            vecs[k].s       = 3'(k);
            vecs[k].i       = 1'b1;
            vecs[k].v       = 1'b1;
            vecs[k].ordy    = 8'hFF;
            vecs[k].exp_rdy = 1'b1;
            vecs[k].exp_cur = 3'(k);
            vecs[k].exp_ov  = 8'(1 << k);
            vecs[k].exp_o   = 8'((2 << k) - 1);
        end
        // Scan beats 0..7 write 0 (clearing O bit by bit), beats 8,9 write 1.
        // S is held at 6 to show it is ignored in scan mode.
        for (int j = 0; j < 10; j++) begin
            vecs[8+j].m       = 1'b1;
            vecs[8+j].s       = 3'd6;
            vecs[8+j].i       = (j >= 8);
            vecs[8+j].v       = 1'b1;
            vecs[8+j].ordy    = 8'hFF;
            vecs[8+j].exp_rdy = 1'b1;
            vecs[8+j].exp_cur = 3'(j % 8);
            vecs[8+j].exp_ov  = 8'(1 << (j % 8));
            vecs[8+j].exp_o   = (j < 8) ? 8'((255 << (j + 1)) & 255)
                                        : ((j == 8) ? 8'h01 : 8'h03);
        end

        // ---------------- Reset with a beat presented ----------------
        rst = 1'b1;
        drive8(1'b0, 3'd3, 1'b1, 1'b1, 8'hFF);
        m6 = 1'b0; s6 = 3'd0; i6 = 1'b0; v6 = 1'b0; ordy6 = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_O", 32'(o8), 32'h00);
        chk("reset_o_valid", 32'(ov8), 32'h00);
        chk("reset_sel_err", 32'(err8), 32'h0);
        chk("reset_cur_sel", 32'(cur8), 32'h3);
        chk("reset_o_valid6", 32'(ov6), 32'h00);
        $display("txn reset: O=%02h o_valid=%02h sel_err=%0b cur_sel=%0d", o8, ov8, err8, cur8);
        rst = 1'b0;
        v8  = 1'b0;
        tick();

        // ---------------- Table-driven sweep + scan ----------------
        for (int n = 0; n < 18; n++) begin
            drive8(vecs[n].m, vecs[n].s, vecs[n].i, vecs[n].v, vecs[n].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", n), 32'(rdy8), 32'(vecs[n].exp_rdy));
            chk($sformatf("vec%0d_cur_sel", n), 32'(cur8), 32'(vecs[n].exp_cur));
            tick();
            chk($sformatf("vec%0d_o_valid", n), 32'(ov8), 32'(vecs[n].exp_ov));
            chk($sformatf("vec%0d_O", n), 32'(o8), 32'(vecs[n].exp_o));
            $display("txn vec%0d: mode=%0b S=%0d I=%0b cur_sel=%0d o_valid=%02h O=%02h",
                     n, vecs[n].m, vecs[n].s, vecs[n].i, cur8, ov8, o8);
        end
        // Scan counter now at 2; O=03, o_valid=02.

        // ---------------- Scan stall on a full slot ----------------
        // Fill slot 5 directly while its consumer is stalled.
        drive8(1'b0, 3'd5, 1'b1, 1'b1, 8'hDF);
        tick();
        chk("stall_preload_o_valid5", 32'(ov8[5]), 32'h1);
        // Scan mode: targets 2,3,4 accepted, then blocked at 5.
        drive8(1'b1, 3'd0, 1'b1, 1'b1, 8'hDF);
        for (int t = 2; t < 5; t++) begin
            #1;
            chk($sformatf("scan%0d_cur_sel", t), 32'(cur8), 32'(t));
            tick();
        end
        for (int t = 0; t < 2; t++) begin
            chk("stall_cur_sel", 32'(cur8), 32'h5);
            chk("stall_in_ready", 32'(rdy8), 32'h0);
            tick();
        end
        $display("txn scan_stall: cur_sel=%0d in_ready=%0b o_valid=%02h", cur8, rdy8, ov8);
        ordy8 = 8'hFF;
        #1;
        chk("unstall_in_ready", 32'(rdy8), 32'h1);
        tick();
        chk("unstall_cur_sel", 32'(cur8), 32'h6);
        chk("unstall_o_valid5", 32'(ov8[5]), 32'h1);

        // ---------------- Backpressure on channel 2 ----------------
        drive8(1'b0, 3'd2, 1'b1, 1'b1, 8'hFB);
        #1;
        chk("bp_first_in_ready", 32'(rdy8), 32'h1);
        tick();
        chk("bp_first_o_valid2", 32'(ov8[2]), 32'h1);
        chk("bp_first_O2", 32'(o8[2]), 32'h1);
        i8 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            #1;
            chk("bp_blocked_in_ready", 32'(rdy8), 32'h0);
            tick();
            chk("bp_blocked_O2", 32'(o8[2]), 32'h1);
            chk("bp_blocked_o_valid2", 32'(ov8[2]), 32'h1);
        end
        ordy8 = 8'hFF;
        #1;
        chk("bp_release_in_ready", 32'(rdy8), 32'h1);
        tick();
        chk("bp_loadwins_O2", 32'(o8[2]), 32'h0);
        chk("bp_loadwins_o_valid2", 32'(ov8[2]), 32'h1);
        v8 = 1'b0;
        tick();
        chk("bp_drained_o_valid2", 32'(ov8[2]), 32'h0);
        $display("txn backpressure: O=%02h o_valid=%02h", o8, ov8);

        // ---------------- Independent drain ----------------
        // O[6] is 0 here (written 0 during scan), so a retained 1 is visible.
        drive8(1'b0, 3'd1, 1'b1, 1'b1, 8'h00);
        tick();
        drive8(1'b0, 3'd6, 1'b1, 1'b1, 8'h00);
        tick();
        v8 = 1'b0;
        chk("drain_loaded_o_valid", 32'(ov8), 32'h42);
        ordy8 = 8'h40;
        tick();
        chk("drain_o_valid", 32'(ov8), 32'h02);
        chk("drain_O6_retained", 32'(o8[6]), 32'h1);
        chk("drain_O1", 32'(o8[1]), 32'h1);
        chk("no_sel_err8", 32'(err8), 32'h0);
        $display("txn drain: o_valid=%02h O=%02h", ov8, o8);

        // ---------------- Out-of-range on the 6-channel instance ----------------
        m6 = 1'b0; s6 = 3'd3; i6 = 1'b1; v6 = 1'b1; ordy6 = 6'h00;
        tick();
        chk("oor_pre_o_valid6", 32'(ov6), 32'h08);
        s6 = 3'd7;
        #1;
        chk("oor_in_ready6", 32'(rdy6), 32'h1);
        chk("oor_cur_sel6", 32'(cur6), 32'h7);
        chk("oor_sel_err_before", 32'(err6), 32'h0);
        tick();
        v6 = 1'b0;
        chk("oor_o_valid6_unchanged", 32'(ov6), 32'h08);
        chk("oor_sel_err", 32'(err6), 32'h1);
        repeat (3) tick();
        chk("oor_sel_err_sticky", 32'(err6), 32'h1);
        $display("txn out_of_range: o_valid6=%02h sel_err6=%0b", ov6, err6);

        // ---------------- Mid-operation reset ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_sel_err6", 32'(err6), 32'h0);
        chk("rst_o_valid6", 32'(ov6), 32'h00);
        chk("rst_O6", 32'(o6), 32'h00);
        chk("rst_o_valid8", 32'(ov8), 32'h00);
        chk("rst_O8", 32'(o8), 32'h00);
        // Scan counter back at 0 after reset.
        m8 = 1'b1;
        #1;
        chk("rst_scan_cur_sel", 32'(cur8), 32'h0);
        $display("txn mid_reset: o_valid=%02h O=%02h o_valid6=%02h", ov8, o8, ov6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
